// File: rtl/move_collector.sv
// move_collector: snapshots NUM_CH move channels and streams the non-empty moves out through a FIFO
// Optional capture-first two-pass ordering: define MOVE_COLLECTOR_CAPTURE_FIRST_EN
`timescale 1ns/1ps
module move_collector #(
    parameter int NUM_CH = 16,
    parameter int DEPTH  = 8,
    parameter int MOVE_W = 32
) (
    input  logic                        clk,
    input  logic                        clear,
    input  logic                        enable,
    input  logic                        start,
    input  logic [NUM_CH*MOVE_W-1:0]    move_in,
    output logic                        busy,
    output logic                        done,
    output logic [MOVE_W-1:0]           move_out,
    output logic                        move_valid,
    input  logic                        move_ready,
    output logic [$clog2(NUM_CH+1)-1:0] move_count,
    output logic [$clog2(DEPTH+1)-1:0]  fifo_level
);
    localparam int IW = $clog2(NUM_CH);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
    typedef enum logic [2:0] {IDLE, SCAN, SCAN2, DRAIN, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, DONE} state_t;
`endif

    state_t            state;
    logic [IW-1:0]     idx;
    logic [MOVE_W-1:0] snap [NUM_CH];
    logic [MOVE_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [MOVE_W-1:0] last_out;
    logic [MOVE_W-1:0] cur;
    logic              scanning, want, full, push, adv, pop, last_ch;

    // An empty FIFO keeps presenting the word that was last at its head
    assign move_valid = fifo_level != '0;
    assign move_out   = move_valid ? mem[rd_ptr] : last_out;

    // Per-cycle scan decision: which channel is examined, whether it is pushed or stalls
    always_comb begin
        cur     = snap[idx];
        full    = fifo_level == LW'(DEPTH);
        last_ch = idx == IW'(NUM_CH-1);
`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
        scanning = state == SCAN || state == SCAN2;
        want     = (state == SCAN && cur[29:24] != '0) || (state == SCAN2 && cur != '0 && cur[29:24] == '0);
`else
        scanning = state == SCAN;
        want     = state == SCAN && cur != '0;
`endif
        push = scanning && enable && want && !full;
        adv  = scanning && enable && !(want && full);
        pop  = move_valid && move_ready;
    end

    // Control FSM: snapshot on start, walk the channels, wait for drain, pulse done
    always_ff @(posedge clk) begin
        if (clear) begin
            state      <= IDLE;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            move_count <= '0;
        end else begin
            done <= 1'b0;
            if (push) move_count <= move_count + 1'b1;
            if (adv) idx <= last_ch ? '0 : idx + 1'b1;
            case (state)
                IDLE: if (start) begin
                    for (int i = 0; i < NUM_CH; i++) snap[i] <= move_in[i*MOVE_W +: MOVE_W];
                    idx        <= '0;
                    move_count <= '0;
                    busy       <= 1'b1;
                    state      <= SCAN;
                end
`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
                SCAN:  if (adv && last_ch) state <= SCAN2;
                SCAN2: if (adv && last_ch) state <= DRAIN;
`else
                SCAN:  if (adv && last_ch) state <= DRAIN;
`endif
                DRAIN: if (!move_valid) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO bookkeeping; a full FIFO refuses a push even if a pop frees space this cycle
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            last_out   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            if (move_valid) last_out <= mem[rd_ptr];
        end
    end

    // FIFO storage, no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cur;
    end
endmodule

// File: tb/tb_move_collector.sv
// tb_move_collector: table-driven and randomized checks of move_collector against an ordering model
`timescale 1ns/1ps
module tb_move_collector;
    localparam int NUM_CH = 16;
    localparam int DEPTH  = 8;
    localparam int MOVE_W = 32;
    localparam int LIMIT  = 2000;
`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif
    localparam int OFF = CAP ? NUM_CH : 0;

    logic clk = 1'b0;
    logic clear, enable, start, move_ready, busy, done, move_valid;
    logic [NUM_CH*MOVE_W-1:0] move_in;
    logic [MOVE_W-1:0] move_out;
    logic [4:0] move_count;
    logic [3:0] fifo_level;

    move_collector #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .MOVE_W(MOVE_W)) dut (
        .clk(clk), .clear(clear), .enable(enable), .start(start), .move_in(move_in),
        .busy(busy), .done(done), .move_out(move_out), .move_valid(move_valid),
        .move_ready(move_ready), .move_count(move_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int n_done, cyc = 0, t_last_pop, t_done;
    int rdy_kind = 0, release_k = 0, frz_at = -100, frz_len = 0, chk_at = -1;
    bit glitch = 0, rnd_en = 0;
    logic [MOVE_W-1:0] got[$];
    logic [MOVE_W-1:0] exp_q[$];

    // Consumer side: record every accepted word and every done pulse
    always @(negedge clk) begin
        cyc++;
        if (move_valid && move_ready) begin
            got.push_back(move_out);
            t_last_pop = cyc;
        end
        if (done) begin
            n_done++;
            t_done = cyc;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Expected output: non-empty words in channel order, captures first when enabled
    function automatic void build_exp(input logic [NUM_CH*MOVE_W-1:0] v);
        logic [MOVE_W-1:0] w;
        exp_q = {};
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < NUM_CH; c++) begin
                w = v[c*MOVE_W +: MOVE_W];
                if (w != 0 && (CAP ? ((p == 0) == (w[29:24] != 0)) : p == 0)) exp_q.push_back(w);
            end
    endfunction

    task automatic run_scan(input logic [NUM_CH*MOVE_W-1:0] v, output int first_valid);
        int k;
        logic [4:0] ref_cnt;
        logic [3:0] ref_lvl;
        build_exp(v);
        got = {};
        n_done = 0;
        t_last_pop = 0;
        t_done = 0;
        ref_cnt = '0;
        ref_lvl = '0;
        move_in = v;
        start = 1'b1;
        enable = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        first_valid = -1;
        for (k = 1; k <= LIMIT; k++) begin
            enable = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            case (rdy_kind)
                0: move_ready = 1'b1;
                1: move_ready = 1'($urandom_range(0, 1));
                default: move_ready = k >= release_k;
            endcase
            if (glitch && k == 2) begin
                start = 1'b1;
                move_in = ~v;
            end
            if (glitch && k == 3) start = 1'b0;
            if (k == frz_at) begin
                ref_cnt = move_count;
                ref_lvl = fifo_level;
            end
            if (k >= frz_at && k < frz_at + frz_len) begin
                enable = 1'b0;
                move_ready = 1'b0;
            end
            @(posedge clk); #1;
            if (first_valid < 0 && move_valid) first_valid = k;
            if (k >= frz_at && k < frz_at + frz_len) begin
                chk("freeze_count", move_count, ref_cnt);
                chk("freeze_level", fifo_level, ref_lvl);
            end
            if (k == chk_at) begin
                chk("bp_level", fifo_level, DEPTH);
                chk("bp_count", move_count, DEPTH);
            end
            if (!busy) break;
        end
        chk("timeout", k <= LIMIT, 1);
        chk("done_pulses", n_done, 1);
        chk("count", move_count, exp_q.size());
        chk("n_words", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk("word", got[i], exp_q[i]);
        chk("end_valid", move_valid, 0);
        chk("end_level", fifo_level, 0);
        if (exp_q.size() != 0) begin
            chk("hold_out", move_out, exp_q[exp_q.size()-1]);
            chk("done_after_pop", t_done > t_last_pop, 1);
        end
    endtask

    typedef struct {
        int ch;
        logic [31:0] w;
        int lat;
        int cnt;
    } vec_t;
    vec_t tbl[6];

    initial begin
        logic [NUM_CH*MOVE_W-1:0] v, vbp;
        logic [MOVE_W-1:0] w;
        logic [MOVE_W-1:0] ord[3];
        int fv;
        tbl[0] = '{0,  32'h0015_1814, 1 + OFF,  1};
        tbl[1] = '{3,  32'h0015_1814, 4 + OFF,  1};
        tbl[2] = '{7,  32'h2215_1814, 8,        1};
        tbl[3] = '{15, 32'h0B2B_1810, 16,       1};
        tbl[4] = '{15, 32'h0000_0001, 16 + OFF, 1};
        tbl[5] = '{-1, 32'h0,         -1,       0};
        for (int c = 0; c < NUM_CH; c++) vbp[c*MOVE_W +: MOVE_W] = 32'h0000_1800 + c;

        clear = 1'b1; enable = 1'b1; start = 1'b0; move_ready = 1'b1; move_in = '0;
        repeat (2) @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", move_valid, 0);
        chk("rst_out", move_out, 0);
        chk("rst_count", move_count, 0);
        chk("rst_level", fifo_level, 0);
        clear = 1'b0;

        for (int i = 0; i < 6; i++) begin
            v = '0;
            if (tbl[i].ch >= 0) v[tbl[i].ch*MOVE_W +: MOVE_W] = tbl[i].w;
            run_scan(v, fv);
            chk("tbl_latency", fv, tbl[i].lat);
            chk("tbl_count", move_count, tbl[i].cnt);
        end

        move_in = vbp; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; move_ready = 1'b0;
        repeat (5) @(posedge clk); #1;
        clear = 1'b1;
        repeat (2) @(posedge clk); #1;
        clear = 1'b0; move_ready = 1'b1;
        chk("clr_busy", busy, 0);
        chk("clr_valid", move_valid, 0);
        chk("clr_level", fifo_level, 0);
        chk("clr_count", move_count, 0);
        chk("clr_done", done, 0);

        rdy_kind = 2; release_k = 60; chk_at = 59;
        run_scan(vbp, fv);
        rdy_kind = 0; chk_at = -1;

        v = vbp;
        v[2*MOVE_W +: MOVE_W] = '0;
        v[6*MOVE_W +: MOVE_W] = 32'h2215_1814;
        frz_at = 6; frz_len = 5;
        run_scan(v, fv);
        frz_at = -100; frz_len = 0;

        v = '0;
        v[4*MOVE_W +: MOVE_W] = 32'h0015_1814;
        v[11*MOVE_W +: MOVE_W] = 32'h0312_0a05;
        glitch = 1'b1;
        run_scan(v, fv);
        glitch = 1'b0;

        v = '0;
        v[1*MOVE_W +: MOVE_W] = 32'h0015_1814;
        v[5*MOVE_W +: MOVE_W] = 32'h2215_1814;
        v[9*MOVE_W +: MOVE_W] = 32'h0B2B_1810;
        ord = CAP ? '{32'h2215_1814, 32'h0B2B_1810, 32'h0015_1814}
                  : '{32'h0015_1814, 32'h2215_1814, 32'h0B2B_1810};
        run_scan(v, fv);
        chk("order_n", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk("order_word", got[i], ord[i]);

        rdy_kind = 1; rnd_en = 1'b1;
        for (int r = 0; r < 10; r++) begin
            v = '0;
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 1) == 1) begin
                    w = '0;
                    w[29:24] = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
                    w[21:16] = 6'($urandom_range(0, 63));
                    w[13:8]  = 6'($urandom_range(1, 63));
                    w[5:0]   = 6'($urandom_range(0, 63));
                    v[c*MOVE_W +: MOVE_W] = w;
                end
            run_scan(v, fv);
        end
        rdy_kind = 0; rnd_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
